// File: rtl/axis_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and constants for the packet-level AXI-Stream round-robin
// arbiter (axis_rr_arbiter) and its helpers.
//
// Contents:
//   state_t             arbiter FSM states (IDLE, FORWARD, DISCARD)
//   AXIS_ARB_MAX_PORTS  largest supported number of slave streams
//
// DISCARD is only ever entered when the design is built with the optional
// macro AXIS_ARB_MAXLEN_EN. The encoding is still declared unconditionally,
// so both builds share the same state type.
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam int AXIS_ARB_MAX_PORTS = 8;

endpackage : axis_arb_pkg

// File: rtl/axis_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter_if
// Bundles the N_PORTS packed slave streams, the single master stream and
// the grant vector of axis_rr_arbiter.
//
// Parameters:
//   N_PORTS       number of slave streams (must match the arbiter)
//
// Signals:
//   saxis_tdata   [N_PORTS*8-1:0]  slave data, port i at [i*8+:8]
//   saxis_tvalid  [N_PORTS-1:0]    slave valid, port i at [i]
//   saxis_tuser   [N_PORTS-1:0]    slave user bit
//   saxis_tlast   [N_PORTS-1:0]    slave end-of-packet
//   saxis_tready  [N_PORTS-1:0]    per-port ready (from arbiter)
//   maxis_tdata   [7:0]            master data (from arbiter)
//   maxis_tvalid                   master valid (from arbiter)
//   maxis_tuser                    master user bit (from arbiter)
//   maxis_tlast                    master end-of-packet (from arbiter)
//   maxis_tready                   master ready (into arbiter)
//   grant         [N_PORTS-1:0]    one-hot current owner (from arbiter)
//
// Modports:
//   master  the arbiter's view (it is the master of the output stream)
//   slave   the environment's view (sources and sink around the arbiter)
// -----------------------------------------------------------------------------
interface axis_rr_arbiter_if #(
  parameter int N_PORTS = 4
);

  logic [N_PORTS*8-1:0] saxis_tdata;
  logic [N_PORTS-1:0]   saxis_tvalid;
  logic [N_PORTS-1:0]   saxis_tuser;
  logic [N_PORTS-1:0]   saxis_tlast;
  logic [N_PORTS-1:0]   saxis_tready;

  logic [7:0]           maxis_tdata;
  logic                 maxis_tvalid;
  logic                 maxis_tuser;
  logic                 maxis_tlast;
  logic                 maxis_tready;

  logic [N_PORTS-1:0]   grant;

  modport master (
    input  saxis_tdata,
    input  saxis_tvalid,
    input  saxis_tuser,
    input  saxis_tlast,
    output saxis_tready,
    output maxis_tdata,
    output maxis_tvalid,
    output maxis_tuser,
    output maxis_tlast,
    input  maxis_tready,
    output grant
  );

  modport slave (
    output saxis_tdata,
    output saxis_tvalid,
    output saxis_tuser,
    output saxis_tlast,
    input  saxis_tready,
    input  maxis_tdata,
    input  maxis_tvalid,
    input  maxis_tuser,
    input  maxis_tlast,
    output maxis_tready,
    input  grant
  );

endinterface : axis_rr_arbiter_if

// File: rtl/axis_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotating-priority picker. Chooses the first
// requesting port searching upward from (last_grant+1) mod N_PORTS,
// wrapping around to port 0.
//
// Parameters:
//   N_PORTS     number of requesters
//   IW          width of a port index
//
// Ports:
//   request     [N_PORTS-1:0]  request vector (one bit per port)
//   last_grant  [IW-1:0]       index of the most recently served port
//   onehot      [N_PORTS-1:0]  one-hot selected port (zero if no request)
//   valid                      at least one port is requesting
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_PORTS = 4,
  parameter int IW      = 2
) (
  input  logic [N_PORTS-1:0] request,
  input  logic [IW-1:0]      last_grant,
  output logic [N_PORTS-1:0] onehot,
  output logic               valid
);

  logic [N_PORTS-1:0] upper_mask;
  logic [N_PORTS-1:0] upper_req;
  logic [N_PORTS-1:0] pick_src;

  // upper_mask marks the ports strictly above last_grant: these come first
  // in the rotation, the ports at or below last_grant follow after the wrap.
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_mask
      localparam logic [IW-1:0] PORT_IDX = IW'(gi);
      assign upper_mask[gi] = (PORT_IDX > last_grant);
    end
  endgenerate

  assign upper_req = request & upper_mask;

  // If nobody above last_grant is requesting, the search has wrapped and
  // the lowest requester overall wins.
  assign pick_src = (|upper_req) ? upper_req : request;

  // Isolate the lowest set bit (two's-complement trick).
  assign onehot = pick_src & (~pick_src + N_PORTS'(1));
  assign valid  = |request;

endmodule : rr_pick

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-granular round-robin arbiter merging N_PORTS AXI-Stream slaves
// (8-bit tdata, 1-bit tuser, tlast) onto one registered master stream.
// A granted port owns the output until its tlast beat is accepted; the
// next owner is chosen in IDLE by rotating priority after the last owner.
//
// Parameters:
//   N_PORTS   number of slave streams, 2..8
//   MAX_LEN   max beats per packet (used only with AXIS_ARB_MAXLEN_EN)
//
// Ports:
//   clock     single clock, rising edge
//   aresetn   asynchronous active-low reset
//   bus       axis_rr_arbiter_if.master: saxis_* slave streams and
//             saxis_tready, registered maxis_* stream and maxis_tready,
//             one-hot grant (zero when idle)
//
// Optional feature (macro AXIS_ARB_MAXLEN_EN):
//   Counts beats of the granted packet. When beat MAX_LEN is accepted
//   without tlast, it is output with tuser=1, tlast=1 and the rest of the
//   source packet is swallowed in DISCARD until its tlast. Without the
//   macro there is no counter, no DISCARD, and packets pass unmodified.
// -----------------------------------------------------------------------------
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int MAX_LEN = 1518
) (
  input  logic               clock,
  input  logic               aresetn,
  axis_rr_arbiter_if.master  bus
);

  localparam int IW = $clog2(N_PORTS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_reg;
  logic [N_PORTS-1:0]   grant_reg;
  logic [IW-1:0]        gidx_reg;        // index form of grant_reg
  logic [IW-1:0]        last_grant_reg;

  logic [7:0]           maxis_tdata_reg;
  logic                 maxis_tvalid_reg;
  logic                 maxis_tuser_reg;
  logic                 maxis_tlast_reg;

`ifdef AXIS_ARB_MAXLEN_EN
  logic [15:0]          beat_cnt_reg;
  logic [15:0]          beat_cnt_next;
  logic                 truncate;
`else
  // MAX_LEN only matters when truncation is built in.
  logic                 unused_max_len;
  assign unused_max_len = (MAX_LEN != 0);
`endif

  // ---------------------------------------------------------------------------
  // Rotating-priority pick
  // ---------------------------------------------------------------------------
  logic [N_PORTS-1:0]   pick_onehot;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IW      (IW)
  ) u_rr_pick (
    .request    (bus.saxis_tvalid),
    .last_grant (last_grant_reg),
    .onehot     (pick_onehot),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick_onehot[i]) begin
        pick_idx = IW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted-port beat selection
  // ---------------------------------------------------------------------------
  logic [7:0]           sel_tdata;
  logic                 sel_tuser;
  logic                 sel_tlast;

  always_comb begin
    sel_tdata = '0;
    sel_tuser = 1'b0;
    sel_tlast = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gidx_reg == IW'(i)) begin
        sel_tdata = bus.saxis_tdata[i*8 +: 8];
        sel_tuser = bus.saxis_tuser[i];
        sel_tlast = bus.saxis_tlast[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ready generation
  // ---------------------------------------------------------------------------
  // The output register can take a new beat when it is empty or being
  // emptied this cycle, which keeps the stream at full rate without a
  // skid buffer while never overwriting an unaccepted beat.
  logic                 out_free;
  logic [N_PORTS-1:0]   ready_vec;
  logic                 accept;

  assign out_free = !maxis_tvalid_reg || bus.maxis_tready;

  always_comb begin
    ready_vec = '0;
    case (state_reg)
      FORWARD: ready_vec = grant_reg & {N_PORTS{out_free}};
`ifdef AXIS_ARB_MAXLEN_EN
      // Dropped beats never reach the output register, so no backpressure.
      DISCARD: ready_vec = grant_reg;
`endif
      default: ready_vec = '0;
    endcase
  end

  assign accept = |(ready_vec & bus.saxis_tvalid);

`ifdef AXIS_ARB_MAXLEN_EN
  assign beat_cnt_next = beat_cnt_reg + 16'd1;
  assign truncate      = !sel_tlast && (beat_cnt_next == 16'(MAX_LEN));
`endif

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      gidx_reg         <= '0;
      last_grant_reg   <= IW'(N_PORTS - 1);
      maxis_tdata_reg  <= '0;
      maxis_tvalid_reg <= 1'b0;
      maxis_tuser_reg  <= 1'b0;
      maxis_tlast_reg  <= 1'b0;
`ifdef AXIS_ARB_MAXLEN_EN
      beat_cnt_reg     <= '0;
`endif
    end else begin
      // The output register drains in every state; a beat loaded below in
      // the same cycle takes precedence.
      if (maxis_tvalid_reg && bus.maxis_tready) begin
        maxis_tvalid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= pick_onehot;
            gidx_reg  <= pick_idx;
            state_reg <= FORWARD;
`ifdef AXIS_ARB_MAXLEN_EN
            beat_cnt_reg <= '0;
`endif
          end
        end

        FORWARD: begin
          if (accept) begin
            maxis_tdata_reg  <= sel_tdata;
            maxis_tuser_reg  <= sel_tuser;
            maxis_tlast_reg  <= sel_tlast;
            maxis_tvalid_reg <= 1'b1;
`ifdef AXIS_ARB_MAXLEN_EN
            beat_cnt_reg <= beat_cnt_next;
            if (truncate) begin
              // Close the packet downstream and flag it as cut short.
              maxis_tuser_reg <= 1'b1;
              maxis_tlast_reg <= 1'b1;
              state_reg       <= DISCARD;
            end
`endif
            if (sel_tlast) begin
              state_reg      <= IDLE;
              grant_reg      <= '0;
              last_grant_reg <= gidx_reg;
            end
          end
        end

`ifdef AXIS_ARB_MAXLEN_EN
        DISCARD: begin
          if (accept && sel_tlast) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= gidx_reg;
          end
        end
`endif

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.saxis_tready = ready_vec;
  assign bus.maxis_tdata  = maxis_tdata_reg;
  assign bus.maxis_tvalid = maxis_tvalid_reg;
  assign bus.maxis_tuser  = maxis_tuser_reg;
  assign bus.maxis_tlast  = maxis_tlast_reg;
  assign bus.grant        = grant_reg;

endmodule : axis_rr_arbiter

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed self-checking bench for axis_rr_arbiter (N_PORTS=4, MAX_LEN=4).
// Per-port source queues hold beats as {tuser, tlast, tdata}; inputs are
// driven on the falling edge and outputs sampled 1 ns later. Expected
// output streams and grant orders are written out by hand per test.
// Build with AXIS_ARB_MAXLEN_EN to exercise the truncation variant.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int NP = 4;

  logic clock;
  logic aresetn;

  axis_rr_arbiter_if #(.N_PORTS(NP)) bus ();

  axis_rr_arbiter #(
    .N_PORTS (NP),
    .MAX_LEN (4)
  ) dut (
    .clock   (clock),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks;
  int          errors;
  int          cyc;
  int          stall_from;
  int          stall_len;
  logic [7:0]  hold_exp;
  logic [3:0]  prev_grant;

  logic [9:0]  src_q [NP][$];
  logic [9:0]  got_q [$];
  logic [9:0]  exp_q [$];
  logic [3:0]  grant_log [$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] grant_at(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 4'h0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mvalid"}, 32'(bus.maxis_tvalid), 32'd0);
    check({tag, "_mdata"},  32'(bus.maxis_tdata),  32'd0);
    check({tag, "_mlast"},  32'(bus.maxis_tlast),  32'd0);
    check({tag, "_muser"},  32'(bus.maxis_tuser),  32'd0);
    check({tag, "_grant"},  32'(bus.grant),        32'd0);
    check({tag, "_sready"}, 32'(bus.saxis_tready), 32'd0);
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    bus.saxis_tvalid = '0;
    bus.saxis_tdata  = '0;
    bus.saxis_tlast  = '0;
    bus.saxis_tuser  = '0;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    clear_sources();
    repeat (2) @(negedge clock);
    aresetn = 1'b1;
  endtask

  task automatic start_test();
    cyc        = 0;
    stall_len  = 0;
    stall_from = 0;
    prev_grant = 4'h0;
    got_q.delete();
    exp_q.delete();
    grant_log.delete();
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later.
  task automatic cycle_step();
    logic [9:0] head;
    @(negedge clock);
    bus.maxis_tready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        head = src_q[p][0];
        bus.saxis_tvalid[p]       = 1'b1;
        bus.saxis_tdata[p*8 +: 8] = head[7:0];
        bus.saxis_tlast[p]        = head[8];
        bus.saxis_tuser[p]        = head[9];
      end else begin
        bus.saxis_tvalid[p]       = 1'b0;
        bus.saxis_tdata[p*8 +: 8] = 8'h00;
        bus.saxis_tlast[p]        = 1'b0;
        bus.saxis_tuser[p]        = 1'b0;
      end
    end
    #1;
    if (cyc == 0) begin
      check("idle_ready", 32'(bus.saxis_tready), 32'd0);
      check("idle_grant", 32'(bus.grant), 32'd0);
    end
    if ((stall_len > 0) && (cyc >= stall_from) && (cyc < stall_from + stall_len)) begin
      check($sformatf("hold_data_c%0d", cyc), 32'(bus.maxis_tdata), 32'(hold_exp));
      check($sformatf("hold_valid_c%0d", cyc), 32'(bus.maxis_tvalid), 32'd1);
      check($sformatf("hold_ready_c%0d", cyc), 32'(bus.saxis_tready), 32'd0);
    end
    if (bus.maxis_tvalid && bus.maxis_tready) begin
      got_q.push_back({bus.maxis_tuser, bus.maxis_tlast, bus.maxis_tdata});
      $display("[%0t] out beat data=%02h last=%0b user=%0b", $time,
               bus.maxis_tdata, bus.maxis_tlast, bus.maxis_tuser);
    end
    if ((bus.grant != prev_grant) && (bus.grant != 4'h0)) begin
      grant_log.push_back(bus.grant);
      $display("[%0t] grant %b", $time, bus.grant);
    end
    prev_grant = bus.grant;
    for (int p = 0; p < NP; p++) begin
      if (bus.saxis_tvalid[p] && bus.saxis_tready[p]) head = src_q[p].pop_front();
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle_step();
  endtask

  task automatic verify_output(input string tag);
    logic [31:0] obs;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF;
      check($sformatf("%s_beat%0d", tag, i), obs, 32'(exp_q[i]));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    stall_from = 0;
    stall_len = 0;
    hold_exp = 8'h00;
    prev_grant = 4'h0;
    bus.maxis_tready = 1'b1;
    aresetn = 1'b0;
    clear_sources();

    // Power-on reset values
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs("por");
    @(negedge clock);
    aresetn = 1'b1;

    // T1: ports 0 and 2 request together, last_grant=3 -> port 0 first
    start_test();
    src_q[0].push_back(10'h011); src_q[0].push_back(10'h012); src_q[0].push_back(10'h113);
    src_q[2].push_back(10'h021); src_q[2].push_back(10'h122);
    exp_q.push_back(10'h011); exp_q.push_back(10'h012); exp_q.push_back(10'h113);
    exp_q.push_back(10'h021); exp_q.push_back(10'h122);
    run(30);
    verify_output("t1");
    check("t1_grant0", 32'(grant_at(0)), 32'h1);
    check("t1_grant1", 32'(grant_at(1)), 32'h4);

    // T2: all ports continuously valid with 1-beat packets
    apply_reset();
    start_test();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        src_q[p].push_back(10'h140 + 10'(r * 16) + 10'(p));
        exp_q.push_back(10'h140 + 10'(r * 16) + 10'(p));
      end
    end
    run(30);
    verify_output("t2");
    check("t2_grant0", 32'(grant_at(0)), 32'h1);
    check("t2_grant1", 32'(grant_at(1)), 32'h2);
    check("t2_grant2", 32'(grant_at(2)), 32'h4);
    check("t2_grant3", 32'(grant_at(3)), 32'h8);
    check("t2_grant4", 32'(grant_at(4)), 32'h1);

    // T3: master stalls 5 cycles while beat 0x62 sits in the output register
    start_test();
    src_q[1].push_back(10'h061); src_q[1].push_back(10'h062);
    src_q[1].push_back(10'h063); src_q[1].push_back(10'h164);
    exp_q.push_back(10'h061); exp_q.push_back(10'h062);
    exp_q.push_back(10'h063); exp_q.push_back(10'h164);
    stall_from = 3;
    stall_len  = 5;
    hold_exp   = 8'h62;
    run(30);
    stall_len  = 0;
    verify_output("t3");
    check("t3_grant0", 32'(grant_at(0)), 32'h2);

    // T4: reset asserted while beat 2 of 4 is on offer
    start_test();
    src_q[3].push_back(10'h071); src_q[3].push_back(10'h072);
    src_q[3].push_back(10'h073); src_q[3].push_back(10'h174);
    run(2);
    @(negedge clock);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid");
    apply_reset();
    start_test();
    src_q[0].push_back(10'h081); src_q[0].push_back(10'h182);
    exp_q.push_back(10'h081); exp_q.push_back(10'h182);
    run(30);
    verify_output("t4");
    check("t4_grant0", 32'(grant_at(0)), 32'h1);
    check("t4_ngrants", 32'(grant_log.size()), 32'd1);

    // T5: 6-beat packet followed by a 2-beat packet on port 2
    start_test();
    src_q[2].push_back(10'h091); src_q[2].push_back(10'h092); src_q[2].push_back(10'h093);
    src_q[2].push_back(10'h094); src_q[2].push_back(10'h095); src_q[2].push_back(10'h196);
    src_q[2].push_back(10'h0A1); src_q[2].push_back(10'h1A2);
`ifdef AXIS_ARB_MAXLEN_EN
    exp_q.push_back(10'h091); exp_q.push_back(10'h092); exp_q.push_back(10'h093);
    exp_q.push_back(10'h394);
`else
    exp_q.push_back(10'h091); exp_q.push_back(10'h092); exp_q.push_back(10'h093);
    exp_q.push_back(10'h094); exp_q.push_back(10'h095); exp_q.push_back(10'h196);
`endif
    exp_q.push_back(10'h0A1); exp_q.push_back(10'h1A2);
    run(40);
    verify_output("t5");
    check("t5_src_drained", 32'(src_q[2].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_axis_rr_arbiter
